// File: rtl/hbm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hbm_pkg
// Purpose  : Shared types and helpers for the HBM burst splitter.
// Revision : 1.0 - initial release
// ============================================================================
package hbm_pkg;

  // Largest AxLEN the HBM pseudo-channel port accepts.
  localparam int unsigned HBM_MAX_LEN = 15;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  // WR_BOUT presents the merged response upstream once the last
  // downstream B has been absorbed.
  typedef enum logic [2:0] {
    WR_IDLE = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    WR_BOUT = 3'd4
  } wr_state_e;

  // Numeric max of two BRESP codes: DECERR beats SLVERR beats OKAY.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hbm_split_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : hbm_split_addr_gen
// Purpose  : Holds one AXI request and produces the address/len of the
//            current sub-burst plus a final-sub-burst flag; steps on i_next.
// Revision : 1.0 - initial release
// ============================================================================
module hbm_split_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  input  logic                  i_next,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [7:0]            o_len,
  output logic                  o_final
);
  import hbm_pkg::*;

  localparam logic [8:0] c_beats   = 9'(MAX_BEATS);
  localparam logic [7:0] c_max_len = 8'(MAX_BEATS - 1);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [8:0]            r_rem;    // beats still to issue, 1..256
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic                  r_split;  // only INCR bursts are ever cut

  logic [ADDR_WIDTH-1:0] w_mask;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_next_addr;

  // Later sub-bursts start on a size-aligned boundary, so aligning the
  // current address works for the first (unaligned) and all later steps.
  assign w_mask      = {ADDR_WIDTH{1'b1}} << r_size;
  assign w_step      = ADDR_WIDTH'(MAX_BEATS) << r_size;
  assign w_next_addr = (r_addr & w_mask) + w_step;

  assign o_addr  = r_addr;
  assign o_final = !r_split || (r_rem <= c_beats);
  assign o_len   = !r_split ? r_len :
                   (r_rem > c_beats) ? c_max_len : 8'(r_rem - 9'd1);

  // Request capture and per-sub-burst advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_rem   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_split <= 1'b0;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_rem   <= {1'b0, i_len} + 9'd1;
      r_len   <= i_len;
      r_size  <= i_size;
      r_split <= (i_burst == BURST_INCR);
    end else if (i_next && !o_final) begin
      r_addr  <= w_next_addr;
      r_rem   <= r_rem - c_beats;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hbm_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module   : hbm_burst_splitter
// Purpose  : Cuts long AXI4 INCR bursts into HBM-legal sub-bursts and merges
//            the responses back into one upstream burst. Independent read
//            and write paths, one transaction in flight on each.
// Revision : 1.0 - initial release
// ============================================================================
module hbm_burst_splitter #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 256,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned MAX_BEATS      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  // upstream AR
  input  logic                        i_slv_ar_valid,
  output logic                        o_slv_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]     i_slv_ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_slv_ar_addr,
  input  logic [7:0]                  i_slv_ar_len,
  input  logic [2:0]                  i_slv_ar_size,
  input  logic [1:0]                  i_slv_ar_burst,
  input  logic [3:0]                  i_slv_ar_cache,
  input  logic [2:0]                  i_slv_ar_prot,
  input  logic [3:0]                  i_slv_ar_qos,
  input  logic [AXI_USER_WIDTH-1:0]   i_slv_ar_user,
  // upstream R
  output logic                        o_slv_r_valid,
  input  logic                        i_slv_r_ready,
  output logic [AXI_ID_WIDTH-1:0]     o_slv_r_id,
  output logic [AXI_DATA_WIDTH-1:0]   o_slv_r_data,
  output logic [1:0]                  o_slv_r_resp,
  output logic                        o_slv_r_last,
  output logic [AXI_USER_WIDTH-1:0]   o_slv_r_user,
  // upstream AW
  input  logic                        i_slv_aw_valid,
  output logic                        o_slv_aw_ready,
  input  logic [AXI_ID_WIDTH-1:0]     i_slv_aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_slv_aw_addr,
  input  logic [7:0]                  i_slv_aw_len,
  input  logic [2:0]                  i_slv_aw_size,
  input  logic [1:0]                  i_slv_aw_burst,
  input  logic [3:0]                  i_slv_aw_cache,
  input  logic [2:0]                  i_slv_aw_prot,
  input  logic [3:0]                  i_slv_aw_qos,
  input  logic [AXI_USER_WIDTH-1:0]   i_slv_aw_user,
  // upstream W
  input  logic                        i_slv_w_valid,
  output logic                        o_slv_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_slv_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_slv_w_strb,
  input  logic                        i_slv_w_last,
  input  logic [AXI_USER_WIDTH-1:0]   i_slv_w_user,
  // upstream B
  output logic                        o_slv_b_valid,
  input  logic                        i_slv_b_ready,
  output logic [AXI_ID_WIDTH-1:0]     o_slv_b_id,
  output logic [1:0]                  o_slv_b_resp,
  output logic [AXI_USER_WIDTH-1:0]   o_slv_b_user,
  // downstream AR
  output logic                        o_mst_ar_valid,
  input  logic                        i_mst_ar_ready,
  output logic [AXI_ID_WIDTH-1:0]     o_mst_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   o_mst_ar_addr,
  output logic [7:0]                  o_mst_ar_len,
  output logic [2:0]                  o_mst_ar_size,
  output logic [1:0]                  o_mst_ar_burst,
  output logic [3:0]                  o_mst_ar_cache,
  output logic [2:0]                  o_mst_ar_prot,
  output logic [3:0]                  o_mst_ar_qos,
  output logic [AXI_USER_WIDTH-1:0]   o_mst_ar_user,
  // downstream R
  input  logic                        i_mst_r_valid,
  output logic                        o_mst_r_ready,
  input  logic [AXI_ID_WIDTH-1:0]     i_mst_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   i_mst_r_data,
  input  logic [1:0]                  i_mst_r_resp,
  input  logic                        i_mst_r_last,
  input  logic [AXI_USER_WIDTH-1:0]   i_mst_r_user,
  // downstream AW
  output logic                        o_mst_aw_valid,
  input  logic                        i_mst_aw_ready,
  output logic [AXI_ID_WIDTH-1:0]     o_mst_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   o_mst_aw_addr,
  output logic [7:0]                  o_mst_aw_len,
  output logic [2:0]                  o_mst_aw_size,
  output logic [1:0]                  o_mst_aw_burst,
  output logic [3:0]                  o_mst_aw_cache,
  output logic [2:0]                  o_mst_aw_prot,
  output logic [3:0]                  o_mst_aw_qos,
  output logic [AXI_USER_WIDTH-1:0]   o_mst_aw_user,
  // downstream W
  output logic                        o_mst_w_valid,
  input  logic                        i_mst_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]   o_mst_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] o_mst_w_strb,
  output logic                        o_mst_w_last,
  output logic [AXI_USER_WIDTH-1:0]   o_mst_w_user,
  // downstream B
  input  logic                        i_mst_b_valid,
  output logic                        o_mst_b_ready,
  input  logic [AXI_ID_WIDTH-1:0]     i_mst_b_id,
  input  logic [1:0]                  i_mst_b_resp,
  input  logic [AXI_USER_WIDTH-1:0]   i_mst_b_user
);
  import hbm_pkg::*;

  // ---------------------------------------------------------------- read ---
  rd_state_e r_rd_state, w_rd_state_nxt;

  logic                      w_rd_load;
  logic                      w_rd_next;
  logic                      w_rd_final;
  logic [AXI_ID_WIDTH-1:0]   r_ar_id;
  logic [2:0]                r_ar_size;
  logic [1:0]                r_ar_burst;
  logic [3:0]                r_ar_cache;
  logic [2:0]                r_ar_prot;
  logic [3:0]                r_ar_qos;
  logic [AXI_USER_WIDTH-1:0] r_ar_user;

  hbm_split_addr_gen #(
    .ADDR_WIDTH (AXI_ADDR_WIDTH),
    .MAX_BEATS  (MAX_BEATS)
  ) u_ar_gen (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_rd_load),
    .i_addr  (i_slv_ar_addr),
    .i_len   (i_slv_ar_len),
    .i_size  (i_slv_ar_size),
    .i_burst (i_slv_ar_burst),
    .i_next  (w_rd_next),
    .o_addr  (o_mst_ar_addr),
    .o_len   (o_mst_ar_len),
    .o_final (w_rd_final)
  );

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_rd_state <= RD_IDLE;
    else     r_rd_state <= w_rd_state_nxt;
  end

  // Read FSM next state and AR handshake outputs.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    o_slv_ar_ready = 1'b0;
    o_mst_ar_valid = 1'b0;
    w_rd_load      = 1'b0;
    w_rd_next      = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        o_slv_ar_ready = 1'b1;
        if (i_slv_ar_valid) begin
          w_rd_load      = 1'b1;
          w_rd_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        o_mst_ar_valid = 1'b1;
        if (i_mst_ar_ready) w_rd_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (i_mst_r_valid && i_slv_r_ready && i_mst_r_last) begin
          if (w_rd_final) begin
            w_rd_state_nxt = RD_IDLE;
          end else begin
            w_rd_next      = 1'b1;
            w_rd_state_nxt = RD_ADDR;
          end
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Capture the AR attributes that every sub-burst repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar_id    <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_ar_cache <= '0;
      r_ar_prot  <= '0;
      r_ar_qos   <= '0;
      r_ar_user  <= '0;
    end else if (w_rd_load) begin
      r_ar_id    <= i_slv_ar_id;
      r_ar_size  <= i_slv_ar_size;
      r_ar_burst <= i_slv_ar_burst;
      r_ar_cache <= i_slv_ar_cache;
      r_ar_prot  <= i_slv_ar_prot;
      r_ar_qos   <= i_slv_ar_qos;
      r_ar_user  <= i_slv_ar_user;
    end
  end

  assign o_mst_ar_id    = r_ar_id;
  assign o_mst_ar_size  = r_ar_size;
  assign o_mst_ar_burst = r_ar_burst;
  assign o_mst_ar_cache = r_ar_cache;
  assign o_mst_ar_prot  = r_ar_prot;
  assign o_mst_ar_qos   = r_ar_qos;
  assign o_mst_ar_user  = r_ar_user;

  // R is a zero-latency pass-through; only the last sub-burst closes it.
  assign o_slv_r_valid = i_mst_r_valid && (r_rd_state == RD_DATA);
  assign o_mst_r_ready = i_slv_r_ready && (r_rd_state == RD_DATA);
  assign o_slv_r_id    = i_mst_r_id;
  assign o_slv_r_data  = i_mst_r_data;
  assign o_slv_r_resp  = i_mst_r_resp;
  assign o_slv_r_user  = i_mst_r_user;
  assign o_slv_r_last  = i_mst_r_last && w_rd_final;

  // --------------------------------------------------------------- write ---
  wr_state_e r_wr_state, w_wr_state_nxt;

  logic                      w_wr_load;
  logic                      w_wr_next;
  logic                      w_wr_final;
  logic                      w_w_hs;
  logic                      w_b_hs;
  logic [7:0]                r_wbeat;
  logic [1:0]                r_bresp;
  logic [AXI_ID_WIDTH-1:0]   r_aw_id;
  logic [2:0]                r_aw_size;
  logic [1:0]                r_aw_burst;
  logic [3:0]                r_aw_cache;
  logic [2:0]                r_aw_prot;
  logic [3:0]                r_aw_qos;
  logic [AXI_USER_WIDTH-1:0] r_aw_user;

  hbm_split_addr_gen #(
    .ADDR_WIDTH (AXI_ADDR_WIDTH),
    .MAX_BEATS  (MAX_BEATS)
  ) u_aw_gen (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_wr_load),
    .i_addr  (i_slv_aw_addr),
    .i_len   (i_slv_aw_len),
    .i_size  (i_slv_aw_size),
    .i_burst (i_slv_aw_burst),
    .i_next  (w_wr_next),
    .o_addr  (o_mst_aw_addr),
    .o_len   (o_mst_aw_len),
    .o_final (w_wr_final)
  );

  assign w_w_hs = o_mst_w_valid && i_mst_w_ready;
  assign w_b_hs = (r_wr_state == WR_RESP) && i_mst_b_valid;

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_wr_state <= WR_IDLE;
    else     r_wr_state <= w_wr_state_nxt;
  end

  // Write FSM next state and AW/B handshake outputs.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    o_slv_aw_ready = 1'b0;
    o_mst_aw_valid = 1'b0;
    o_mst_b_ready  = 1'b0;
    o_slv_b_valid  = 1'b0;
    w_wr_load      = 1'b0;
    w_wr_next      = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        o_slv_aw_ready = 1'b1;
        if (i_slv_aw_valid) begin
          w_wr_load      = 1'b1;
          w_wr_state_nxt = WR_ADDR;
        end
      end
      WR_ADDR: begin
        o_mst_aw_valid = 1'b1;
        if (i_mst_aw_ready) w_wr_state_nxt = WR_DATA;
      end
      WR_DATA: begin
        if (w_w_hs && o_mst_w_last) w_wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        o_mst_b_ready = 1'b1;
        if (i_mst_b_valid) begin
          if (w_wr_final) begin
            w_wr_state_nxt = WR_BOUT;
          end else begin
            w_wr_next      = 1'b1;
            w_wr_state_nxt = WR_ADDR;
          end
        end
      end
      WR_BOUT: begin
        o_slv_b_valid = 1'b1;
        if (i_slv_b_ready) w_wr_state_nxt = WR_IDLE;
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Capture the AW attributes that every sub-burst repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_id    <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_aw_cache <= '0;
      r_aw_prot  <= '0;
      r_aw_qos   <= '0;
      r_aw_user  <= '0;
    end else if (w_wr_load) begin
      r_aw_id    <= i_slv_aw_id;
      r_aw_size  <= i_slv_aw_size;
      r_aw_burst <= i_slv_aw_burst;
      r_aw_cache <= i_slv_aw_cache;
      r_aw_prot  <= i_slv_aw_prot;
      r_aw_qos   <= i_slv_aw_qos;
      r_aw_user  <= i_slv_aw_user;
    end
  end

  // Beat counter drives the downstream w_last of each sub-burst.
  always_ff @(posedge clk) begin
    if (rst || w_wr_load) r_wbeat <= '0;
    else if (w_w_hs)      r_wbeat <= o_mst_w_last ? 8'd0 : r_wbeat + 8'd1;
  end

  // Merge downstream B responses, keeping the most severe.
  always_ff @(posedge clk) begin
    if (rst || w_wr_load) r_bresp <= RESP_OKAY;
    else if (w_b_hs)      r_bresp <= worst_resp(r_bresp, i_mst_b_resp);
  end

  assign o_mst_aw_id    = r_aw_id;
  assign o_mst_aw_size  = r_aw_size;
  assign o_mst_aw_burst = r_aw_burst;
  assign o_mst_aw_cache = r_aw_cache;
  assign o_mst_aw_prot  = r_aw_prot;
  assign o_mst_aw_qos   = r_aw_qos;
  assign o_mst_aw_user  = r_aw_user;

  // W passes straight through, but only while a sub-burst is open.
  assign o_mst_w_valid = i_slv_w_valid && (r_wr_state == WR_DATA);
  assign o_slv_w_ready = i_mst_w_ready && (r_wr_state == WR_DATA);
  assign o_mst_w_data  = i_slv_w_data;
  assign o_mst_w_strb  = i_slv_w_strb;
  assign o_mst_w_user  = i_slv_w_user;
  assign o_mst_w_last  = (r_wr_state == WR_DATA) && (r_wbeat == o_mst_aw_len);

  assign o_slv_b_id   = r_aw_id;
  assign o_slv_b_resp = r_bresp;
  assign o_slv_b_user = r_aw_user;

  // Upstream w_last and the downstream B id/user carry no information here.
  logic w_unused;
  assign w_unused = ^{i_slv_w_last, i_mst_b_id, i_mst_b_user};

endmodule
`default_nettype wire

// File: tb/tb_hbm_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hbm_burst_splitter
// Purpose  : Directed self-checking bench for hbm_burst_splitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hbm_burst_splitter;

  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] WRAP = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic i_slv_ar_valid, o_slv_ar_ready;
  logic [5:0] i_slv_ar_id; logic [63:0] i_slv_ar_addr; logic [7:0] i_slv_ar_len;
  logic [2:0] i_slv_ar_size; logic [1:0] i_slv_ar_burst; logic [3:0] i_slv_ar_cache;
  logic [2:0] i_slv_ar_prot; logic [3:0] i_slv_ar_qos; logic [0:0] i_slv_ar_user;
  logic o_slv_r_valid, i_slv_r_ready; logic [5:0] o_slv_r_id; logic [255:0] o_slv_r_data;
  logic [1:0] o_slv_r_resp; logic o_slv_r_last; logic [0:0] o_slv_r_user;
  logic i_slv_aw_valid, o_slv_aw_ready;
  logic [5:0] i_slv_aw_id; logic [63:0] i_slv_aw_addr; logic [7:0] i_slv_aw_len;
  logic [2:0] i_slv_aw_size; logic [1:0] i_slv_aw_burst; logic [3:0] i_slv_aw_cache;
  logic [2:0] i_slv_aw_prot; logic [3:0] i_slv_aw_qos; logic [0:0] i_slv_aw_user;
  logic i_slv_w_valid, o_slv_w_ready; logic [255:0] i_slv_w_data; logic [31:0] i_slv_w_strb;
  logic i_slv_w_last; logic [0:0] i_slv_w_user;
  logic o_slv_b_valid, i_slv_b_ready; logic [5:0] o_slv_b_id; logic [1:0] o_slv_b_resp;
  logic [0:0] o_slv_b_user;
  logic o_mst_ar_valid, i_mst_ar_ready;
  logic [5:0] o_mst_ar_id; logic [63:0] o_mst_ar_addr; logic [7:0] o_mst_ar_len;
  logic [2:0] o_mst_ar_size; logic [1:0] o_mst_ar_burst; logic [3:0] o_mst_ar_cache;
  logic [2:0] o_mst_ar_prot; logic [3:0] o_mst_ar_qos; logic [0:0] o_mst_ar_user;
  logic i_mst_r_valid, o_mst_r_ready; logic [5:0] i_mst_r_id; logic [255:0] i_mst_r_data;
  logic [1:0] i_mst_r_resp; logic i_mst_r_last; logic [0:0] i_mst_r_user;
  logic o_mst_aw_valid, i_mst_aw_ready;
  logic [5:0] o_mst_aw_id; logic [63:0] o_mst_aw_addr; logic [7:0] o_mst_aw_len;
  logic [2:0] o_mst_aw_size; logic [1:0] o_mst_aw_burst; logic [3:0] o_mst_aw_cache;
  logic [2:0] o_mst_aw_prot; logic [3:0] o_mst_aw_qos; logic [0:0] o_mst_aw_user;
  logic o_mst_w_valid, i_mst_w_ready; logic [255:0] o_mst_w_data; logic [31:0] o_mst_w_strb;
  logic o_mst_w_last; logic [0:0] o_mst_w_user;
  logic i_mst_b_valid, o_mst_b_ready; logic [5:0] i_mst_b_id; logic [1:0] i_mst_b_resp;
  logic [0:0] i_mst_b_user;

  hbm_burst_splitter dut (
    .clk(clk), .rst(rst),
    .i_slv_ar_valid(i_slv_ar_valid), .o_slv_ar_ready(o_slv_ar_ready), .i_slv_ar_id(i_slv_ar_id),
    .i_slv_ar_addr(i_slv_ar_addr), .i_slv_ar_len(i_slv_ar_len), .i_slv_ar_size(i_slv_ar_size),
    .i_slv_ar_burst(i_slv_ar_burst), .i_slv_ar_cache(i_slv_ar_cache), .i_slv_ar_prot(i_slv_ar_prot),
    .i_slv_ar_qos(i_slv_ar_qos), .i_slv_ar_user(i_slv_ar_user),
    .o_slv_r_valid(o_slv_r_valid), .i_slv_r_ready(i_slv_r_ready), .o_slv_r_id(o_slv_r_id),
    .o_slv_r_data(o_slv_r_data), .o_slv_r_resp(o_slv_r_resp), .o_slv_r_last(o_slv_r_last),
    .o_slv_r_user(o_slv_r_user),
    .i_slv_aw_valid(i_slv_aw_valid), .o_slv_aw_ready(o_slv_aw_ready), .i_slv_aw_id(i_slv_aw_id),
    .i_slv_aw_addr(i_slv_aw_addr), .i_slv_aw_len(i_slv_aw_len), .i_slv_aw_size(i_slv_aw_size),
    .i_slv_aw_burst(i_slv_aw_burst), .i_slv_aw_cache(i_slv_aw_cache), .i_slv_aw_prot(i_slv_aw_prot),
    .i_slv_aw_qos(i_slv_aw_qos), .i_slv_aw_user(i_slv_aw_user),
    .i_slv_w_valid(i_slv_w_valid), .o_slv_w_ready(o_slv_w_ready), .i_slv_w_data(i_slv_w_data),
    .i_slv_w_strb(i_slv_w_strb), .i_slv_w_last(i_slv_w_last), .i_slv_w_user(i_slv_w_user),
    .o_slv_b_valid(o_slv_b_valid), .i_slv_b_ready(i_slv_b_ready), .o_slv_b_id(o_slv_b_id),
    .o_slv_b_resp(o_slv_b_resp), .o_slv_b_user(o_slv_b_user),
    .o_mst_ar_valid(o_mst_ar_valid), .i_mst_ar_ready(i_mst_ar_ready), .o_mst_ar_id(o_mst_ar_id),
    .o_mst_ar_addr(o_mst_ar_addr), .o_mst_ar_len(o_mst_ar_len), .o_mst_ar_size(o_mst_ar_size),
    .o_mst_ar_burst(o_mst_ar_burst), .o_mst_ar_cache(o_mst_ar_cache), .o_mst_ar_prot(o_mst_ar_prot),
    .o_mst_ar_qos(o_mst_ar_qos), .o_mst_ar_user(o_mst_ar_user),
    .i_mst_r_valid(i_mst_r_valid), .o_mst_r_ready(o_mst_r_ready), .i_mst_r_id(i_mst_r_id),
    .i_mst_r_data(i_mst_r_data), .i_mst_r_resp(i_mst_r_resp), .i_mst_r_last(i_mst_r_last),
    .i_mst_r_user(i_mst_r_user),
    .o_mst_aw_valid(o_mst_aw_valid), .i_mst_aw_ready(i_mst_aw_ready), .o_mst_aw_id(o_mst_aw_id),
    .o_mst_aw_addr(o_mst_aw_addr), .o_mst_aw_len(o_mst_aw_len), .o_mst_aw_size(o_mst_aw_size),
    .o_mst_aw_burst(o_mst_aw_burst), .o_mst_aw_cache(o_mst_aw_cache), .o_mst_aw_prot(o_mst_aw_prot),
    .o_mst_aw_qos(o_mst_aw_qos), .o_mst_aw_user(o_mst_aw_user),
    .o_mst_w_valid(o_mst_w_valid), .i_mst_w_ready(i_mst_w_ready), .o_mst_w_data(o_mst_w_data),
    .o_mst_w_strb(o_mst_w_strb), .o_mst_w_last(o_mst_w_last), .o_mst_w_user(o_mst_w_user),
    .i_mst_b_valid(i_mst_b_valid), .o_mst_b_ready(o_mst_b_ready), .i_mst_b_id(i_mst_b_id),
    .i_mst_b_resp(i_mst_b_resp), .i_mst_b_user(i_mst_b_user)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [255:0] pat(input int n, input logic [7:0] tag);
    return {8{tag, 24'(n)}};
  endfunction

  function automatic logic [63:0] exp_sub_addr(input logic [63:0] a, input logic [2:0] sz, input int k);
    logic [63:0] mask;
    mask = ~((64'd1 << sz) - 64'd1);
    return (k == 0) ? a : ((a & mask) + (64'(k * 16) << sz));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    i_slv_ar_valid = 0; i_slv_r_ready = 1; i_slv_aw_valid = 0; i_slv_w_valid = 1;
    i_slv_w_last = 0; i_slv_b_ready = 0; i_mst_ar_ready = 0; i_mst_r_valid = 1;
    i_mst_r_last = 0; i_mst_aw_ready = 0; i_mst_w_ready = 1; i_mst_b_valid = 0;
    i_mst_r_id = 6'h0A; i_mst_r_resp = 2'b00; i_mst_r_user = 1'b0; i_mst_r_data = '0;
    i_slv_w_data = '0; i_slv_w_strb = '1; i_slv_w_user = 1'b0;
    i_mst_b_id = 6'h15; i_mst_b_resp = 2'b00; i_mst_b_user = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    n_tests++; if (o_slv_ar_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ar_ready got %b exp 1", o_slv_ar_ready); end
    n_tests++; if (o_slv_aw_ready !== 1'b1) begin n_fail++; $display("FAIL reset_aw_ready got %b exp 1", o_slv_aw_ready); end
    n_tests++; if (o_mst_ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ar_valid got %b exp 0", o_mst_ar_valid); end
    n_tests++; if (o_mst_aw_valid !== 1'b0) begin n_fail++; $display("FAIL reset_aw_valid got %b exp 0", o_mst_aw_valid); end
    n_tests++; if (o_slv_b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got %b exp 0", o_slv_b_valid); end
    n_tests++; if (o_mst_w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_gate got %b exp 0", o_mst_w_valid); end
    n_tests++; if (o_slv_r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_r_gate got %b exp 0", o_slv_r_valid); end
    i_slv_w_valid = 0; i_mst_r_valid = 0;
  endtask

  task automatic test_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit stall);
    int nsub, exp_len, i, guard, gbeat;
    logic v, rr;
    logic [63:0] ea;
    nsub  = (burst == INCR) ? (int'(len) + 16) / 16 : 1;
    gbeat = 0;
    i_slv_ar_id = 6'h0A; i_slv_ar_addr = addr; i_slv_ar_len = len; i_slv_ar_size = size;
    i_slv_ar_burst = burst; i_slv_ar_cache = 4'h2; i_slv_ar_prot = 3'h1; i_slv_ar_qos = 4'h5;
    i_slv_ar_user = 1'b1; i_slv_ar_valid = 1'b1;
    #1;
    n_tests++; if (o_slv_ar_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ar_ready got %b exp 1", o_slv_ar_ready); end
    cyc();
    i_slv_ar_valid = 1'b0;
    for (int k = 0; k < nsub; k++) begin
      exp_len = (burst != INCR) ? int'(len) : (((int'(len) + 1 - 16 * k) > 16) ? 15 : (int'(len) - 16 * k));
      ea = exp_sub_addr(addr, size, k);
      n_tests++; if (o_mst_ar_valid !== 1'b1) begin n_fail++; $display("FAIL rd_ar_valid sub %0d got %b exp 1", k, o_mst_ar_valid); return; end
      n_tests++; if (o_mst_ar_addr !== ea) begin n_fail++; $display("FAIL rd_ar_addr sub %0d got %h exp %h", k, o_mst_ar_addr, ea); end
      n_tests++; if (o_mst_ar_len !== 8'(exp_len)) begin n_fail++; $display("FAIL rd_ar_len sub %0d got %0d exp %0d", k, o_mst_ar_len, exp_len); end
      n_tests++;
      if ({o_mst_ar_id, o_mst_ar_size, o_mst_ar_burst, o_mst_ar_cache, o_mst_ar_prot, o_mst_ar_qos, o_mst_ar_user} !==
          {6'h0A, size, burst, 4'h2, 3'h1, 4'h5, 1'b1}) begin
        n_fail++; $display("FAIL rd_ar_fields sub %0d got %h/%h/%h/%h/%h/%h/%h", k, o_mst_ar_id, o_mst_ar_size,
                           o_mst_ar_burst, o_mst_ar_cache, o_mst_ar_prot, o_mst_ar_qos, o_mst_ar_user);
      end
      if (stall) begin
        repeat (2) cyc();
        n_tests++; if ({o_mst_ar_valid, o_mst_ar_addr, o_mst_ar_len} !== {1'b1, ea, 8'(exp_len)}) begin
          n_fail++; $display("FAIL rd_ar_hold sub %0d got %b %h %0d exp 1 %h %0d", k, o_mst_ar_valid, o_mst_ar_addr, o_mst_ar_len, ea, exp_len); end
      end
      i_mst_ar_ready = 1'b1;
      cyc();
      i_mst_ar_ready = 1'b0;
      i = 0; guard = 0;
      while (i <= exp_len) begin
        if (guard > 200) begin n_tests++; n_fail++; $display("FAIL rd_beat_timeout sub %0d beat %0d", k, i); return; end
        v  = stall ? ((guard % 4) != 2) : 1'b1;
        rr = stall ? ((guard % 3) != 1) : 1'b1;
        i_mst_r_valid = v; i_mst_r_data = pat(gbeat, 8'hA5); i_mst_r_last = (i == exp_len);
        i_slv_r_ready = rr;
        #1;
        n_tests++; if ({o_slv_r_valid, o_mst_r_ready} !== {v, rr}) begin n_fail++; $display("FAIL rd_r_hs got %b%b exp %b%b", o_slv_r_valid, o_mst_r_ready, v, rr); end
        if (v) begin
          n_tests++; if (o_slv_r_data !== pat(gbeat, 8'hA5)) begin n_fail++; $display("FAIL rd_r_data beat %0d got %h", gbeat, o_slv_r_data); end
          n_tests++; if (o_slv_r_last !== (gbeat == int'(len))) begin n_fail++; $display("FAIL rd_r_last beat %0d got %b exp %b", gbeat, o_slv_r_last, gbeat == int'(len)); end
          n_tests++; if (o_slv_r_id !== 6'h0A) begin n_fail++; $display("FAIL rd_r_id got %h exp 0a", o_slv_r_id); end
        end
        cyc();
        if (v && rr) begin i++; gbeat++; end
        guard++;
      end
      i_mst_r_valid = 1'b0; i_mst_r_last = 1'b0;
    end
    n_tests++; if (o_slv_ar_ready !== 1'b1) begin n_fail++; $display("FAIL rd_done_idle got %b exp 1", o_slv_ar_ready); end
  endtask

  task automatic test_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input int err_sub, input logic [1:0] err_resp, input logic [1:0] exp_resp,
                            input bit stall);
    int nsub, exp_len, i, guard, gbeat;
    logic v, rd;
    logic [63:0] ea;
    nsub  = (int'(len) + 16) / 16;
    gbeat = 0;
    i_slv_aw_id = 6'h15; i_slv_aw_addr = addr; i_slv_aw_len = len; i_slv_aw_size = size;
    i_slv_aw_burst = INCR; i_slv_aw_cache = 4'h3; i_slv_aw_prot = 3'h2; i_slv_aw_qos = 4'h1;
    i_slv_aw_user = 1'b1; i_slv_aw_valid = 1'b1;
    #1;
    n_tests++; if (o_slv_aw_ready !== 1'b1) begin n_fail++; $display("FAIL wr_aw_ready got %b exp 1", o_slv_aw_ready); end
    cyc();
    i_slv_aw_valid = 1'b0;
    for (int k = 0; k < nsub; k++) begin
      exp_len = ((int'(len) + 1 - 16 * k) > 16) ? 15 : (int'(len) - 16 * k);
      ea = exp_sub_addr(addr, size, k);
      n_tests++; if (o_mst_aw_valid !== 1'b1) begin n_fail++; $display("FAIL wr_aw_valid sub %0d got %b exp 1", k, o_mst_aw_valid); return; end
      n_tests++; if (o_mst_aw_addr !== ea) begin n_fail++; $display("FAIL wr_aw_addr sub %0d got %h exp %h", k, o_mst_aw_addr, ea); end
      n_tests++; if (o_mst_aw_len !== 8'(exp_len)) begin n_fail++; $display("FAIL wr_aw_len sub %0d got %0d exp %0d", k, o_mst_aw_len, exp_len); end
      n_tests++; if ({o_mst_aw_id, o_mst_aw_burst, o_mst_aw_cache} !== {6'h15, INCR, 4'h3}) begin
        n_fail++; $display("FAIL wr_aw_fields sub %0d got %h/%h/%h", k, o_mst_aw_id, o_mst_aw_burst, o_mst_aw_cache); end
      if (stall) begin
        repeat (2) cyc();
        n_tests++; if ({o_mst_aw_valid, o_mst_aw_addr} !== {1'b1, ea}) begin
          n_fail++; $display("FAIL wr_aw_hold sub %0d got %b %h exp 1 %h", k, o_mst_aw_valid, o_mst_aw_addr, ea); end
      end
      i_mst_aw_ready = 1'b1;
      cyc();
      i_mst_aw_ready = 1'b0;
      i = 0; guard = 0;
      while (i <= exp_len) begin
        if (guard > 200) begin n_tests++; n_fail++; $display("FAIL wr_beat_timeout sub %0d beat %0d", k, i); return; end
        v  = stall ? ((guard % 3) != 2) : 1'b1;
        rd = stall ? ((guard % 4) != 1) : 1'b1;
        i_slv_w_valid = v; i_slv_w_data = pat(gbeat, 8'h3C); i_slv_w_last = (i == 2);
        i_mst_w_ready = rd;
        #1;
        n_tests++; if ({o_mst_w_valid, o_slv_w_ready} !== {v, rd}) begin n_fail++; $display("FAIL wr_w_hs got %b%b exp %b%b", o_mst_w_valid, o_slv_w_ready, v, rd); end
        if (v) begin
          n_tests++; if (o_mst_w_data !== pat(gbeat, 8'h3C)) begin n_fail++; $display("FAIL wr_w_data beat %0d got %h", gbeat, o_mst_w_data); end
          n_tests++; if (o_mst_w_last !== (i == exp_len)) begin n_fail++; $display("FAIL wr_w_last beat %0d got %b exp %b", gbeat, o_mst_w_last, i == exp_len); end
        end
        cyc();
        if (v && rd) begin i++; gbeat++; end
        guard++;
      end
      i_slv_w_valid = 1'b1; i_slv_w_last = 1'b0;
      #1;
      n_tests++; if ({o_mst_w_valid, o_mst_b_ready, o_slv_b_valid} !== 3'b010) begin
        n_fail++; $display("FAIL wr_resp_state sub %0d got wv=%b br=%b bv=%b exp 0 1 0", k, o_mst_w_valid, o_mst_b_ready, o_slv_b_valid); end
      i_slv_w_valid = 1'b0;
      if (stall) cyc();
      i_mst_b_valid = 1'b1;
      i_mst_b_resp  = (k == err_sub) ? err_resp : 2'b00;
      cyc();
      i_mst_b_valid = 1'b0;
    end
    n_tests++; if ({o_slv_b_valid, o_slv_b_id, o_slv_b_resp} !== {1'b1, 6'h15, exp_resp}) begin
      n_fail++; $display("FAIL wr_b got v=%b id=%h resp=%b exp v=1 id=15 resp=%b", o_slv_b_valid, o_slv_b_id, o_slv_b_resp, exp_resp); end
    if (stall) begin
      cyc();
      n_tests++; if (o_slv_b_valid !== 1'b1) begin n_fail++; $display("FAIL wr_b_hold got %b exp 1", o_slv_b_valid); end
    end
    i_slv_b_ready = 1'b1;
    cyc();
    i_slv_b_ready = 1'b0;
    n_tests++; if ({o_slv_b_valid, o_slv_aw_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wr_done got bv=%b awr=%b exp 0 1", o_slv_b_valid, o_slv_aw_ready); end
  endtask

  task automatic test_concurrent();
    fork
      test_read(64'h5000, 8'd47, 3'd5, INCR, 1'b1);
      test_write(64'h6008, 8'd31, 3'd5, 1, 2'b11, 2'b11, 1'b1);
    join
  endtask

  task automatic test_reset_mid_burst();
    i_slv_ar_id = 6'h0A; i_slv_ar_addr = 64'h7000; i_slv_ar_len = 8'd63; i_slv_ar_size = 3'd5;
    i_slv_ar_burst = INCR; i_slv_ar_valid = 1'b1;
    cyc();
    i_slv_ar_valid = 1'b0; i_mst_ar_ready = 1'b1;
    cyc();
    i_mst_ar_ready = 1'b0; i_slv_r_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      i_mst_r_valid = 1'b1; i_mst_r_last = (b == 15);
      cyc();
    end
    i_mst_r_valid = 1'b0; i_mst_r_last = 1'b0;
    n_tests++; if ({o_mst_ar_valid, o_mst_ar_addr} !== {1'b1, 64'h7200}) begin
      n_fail++; $display("FAIL rst_sub2_ar got %b %h exp 1 7200", o_mst_ar_valid, o_mst_ar_addr); end
    i_mst_ar_ready = 1'b1;
    cyc();
    i_mst_ar_ready = 1'b0; i_mst_r_valid = 1'b1;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    n_tests++; if ({o_mst_ar_valid, o_slv_r_valid, o_mst_r_ready, o_mst_aw_valid, o_slv_b_valid} !== 5'b00000) begin
      n_fail++; $display("FAIL rst_mid_valids got %b%b%b%b%b exp 00000", o_mst_ar_valid, o_slv_r_valid, o_mst_r_ready, o_mst_aw_valid, o_slv_b_valid); end
    rst = 1'b0; i_mst_r_valid = 1'b0;
    cyc();
    test_read(64'h8000, 8'd0, 3'd5, INCR, 1'b0);
  endtask

  initial begin
    test_reset();
    test_read(64'h1000, 8'd63, 3'd5, INCR, 1'b0);
    test_write(64'h2010, 8'd19, 3'd5, -1, 2'b00, 2'b00, 1'b0);
    test_write(64'h3000, 8'd47, 3'd5, 1, 2'b10, 2'b10, 1'b0);
    test_read(64'h4020, 8'd15, 3'd5, WRAP, 1'b0);
    test_read(64'h4100, 8'd7, 3'd5, INCR, 1'b0);
    test_read(64'h9000, 8'd255, 3'd3, INCR, 1'b0);
    test_write(64'hA000, 8'd16, 3'd5, -1, 2'b00, 2'b00, 1'b0);
    test_concurrent();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
